// File: rtl/splitter_stream.sv
// Word-to-lane stream splitter: captures one DATA_W word, emits LANES lanes over valid/ready.
// Optional lane parity output out_par when SPLIT_PARITY_EN is defined.
module splitter_stream #(
  parameter  int DATA_W = 32,
  parameter  int LANE_W = 8,
  localparam int LANES  = DATA_W / LANE_W,
  localparam int IDX_W  = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_msb_first,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
`ifdef SPLIT_PARITY_EN
  output logic              out_par,
`endif
  output logic              busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LANES - 1);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic              order_q, order_d;

  logic [LANE_W-1:0] lanes [LANES];
  logic [IDX_W-1:0]  lane_sel;
  logic              in_shift;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lanes[gi] = word_q[gi*LANE_W +: LANE_W];
    end
  endgenerate

  assign in_shift  = (state_q == S_SHIFT);
  assign lane_sel  = order_q ? (LAST_BEAT - beat_q) : beat_q;
  assign out_valid = in_shift;
  assign busy      = in_shift;
  assign out_data  = in_shift ? lanes[lane_sel] : '0;
  assign out_idx   = in_shift ? beat_q : '0;
  assign out_last  = in_shift && (beat_q == LAST_BEAT);
  // Accepting on the final beat's transfer gives a zero-bubble word boundary.
  assign in_ready  = !in_shift || (out_last && out_ready);

`ifdef SPLIT_PARITY_EN
  assign out_par = ^out_data;
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    beat_d  = beat_q;
    order_d = order_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          word_d  = in_data;
          order_d = in_msb_first;
          beat_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (out_ready) begin
          if (beat_q != LAST_BEAT) begin
            beat_d = beat_q + IDX_W'(1);
          end else if (in_valid) begin
            word_d  = in_data;
            order_d = in_msb_first;
            beat_d  = '0;
          end else begin
            beat_d  = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      beat_q  <= '0;
      order_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
      order_q <= order_d;
    end
  end

endmodule

// File: tb/tb_splitter_stream.sv
// Directed bench for splitter_stream: ordering, backpressure, back-to-back, async reset.
// Define SPLIT_PARITY_EN to also exercise out_par.
module tb_splitter_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_msb_first;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;
`ifdef SPLIT_PARITY_EN
  logic        out_par;
`endif

  int checks = 0;
  int fails  = 0;

  splitter_stream #(.DATA_W(32), .LANE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last),
`ifdef SPLIT_PARITY_EN
    .out_par      (out_par),
`endif
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, out_data, out_idx, out_last, busy} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b d=%h i=%0d l=%b b=%b, want all 0",
               out_valid, out_data, out_idx, out_last, busy);
    end
    tick;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    tick;
  endtask

  task automatic run_word(input string name, input logic [31:0] w, input logic msb,
                          input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    in_valid = 1'b1; in_data = w; in_msb_first = msb; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: got in_ready=%b out_valid=%b busy=%b, want 1/0/0",
               name, in_ready, out_valid, busy);
    end
    tick;
    in_valid = 1'b0; in_data = 32'hDEADBEEF; in_msb_first = ~msb;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i) ||
          out_last !== (i == 3) || busy !== 1'b1 || in_ready !== (i == 3)) begin
        fails++;
        $display("FAIL %s_beat%0d: got v=%b d=%h i=%0d l=%b b=%b r=%b, want 1 %h %0d %b 1 %b",
                 name, i, out_valid, out_data, out_idx, out_last, busy, in_ready,
                 exp[i], i, (i == 3), (i == 3));
      end
      tick;
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_done: got v=%b r=%b d=%h b=%b, want 0 1 00 0",
               name, out_valid, in_ready, out_data, busy);
    end
    tick;
  endtask

  task automatic test_lsb_first;
    run_word("lsb", 32'h12345678, 1'b0, 8'h78, 8'h56, 8'h34, 8'h12);
  endtask

  task automatic test_msb_first;
    run_word("msb", 32'h12345678, 1'b1, 8'h12, 8'h34, 8'h56, 8'h78);
  endtask

  task automatic test_backpressure;
    in_valid = 1'b1; in_data = 32'h12345678; in_msb_first = 1'b0; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_data !== 8'h78) begin
      fails++;
      $display("FAIL bp_beat0: got %h, want 78", out_data);
    end
    tick;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h56 || out_idx !== 2'd1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b d=%h i=%0d r=%b, want 1 56 1 0",
                 i, out_valid, out_data, out_idx, in_ready);
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_data !== 8'h56 || out_idx !== 2'd1) begin
      fails++;
      $display("FAIL bp_release: got d=%h i=%0d, want 56 1", out_data, out_idx);
    end
    tick;
    #1;
    checks++;
    if (out_data !== 8'h34 || out_idx !== 2'd2) begin
      fails++;
      $display("FAIL bp_resume: got d=%h i=%0d, want 34 2", out_data, out_idx);
    end
    tick;
    tick;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: got out_valid=%b, want 0", out_valid);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [8];
    exp[0] = 8'hDD; exp[1] = 8'hCC; exp[2] = 8'hBB; exp[3] = 8'hAA;
    exp[4] = 8'h04; exp[5] = 8'h03; exp[6] = 8'h02; exp[7] = 8'h01;
    in_valid = 1'b1; in_data = 32'hAABBCCDD; in_msb_first = 1'b0; out_ready = 1'b1;
    tick;
    in_data = 32'h01020304;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i] || out_idx !== 2'(i % 4) ||
          in_ready !== (i == 3 || i == 7)) begin
        fails++;
        $display("FAIL b2b_beat%0d: got v=%b d=%h i=%0d r=%b, want 1 %h %0d %b",
                 i, out_valid, out_data, out_idx, in_ready, exp[i], i % 4, (i == 3 || i == 7));
      end
      tick;
      if (i == 3) in_valid = 1'b0;
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_done: got v=%b b=%b, want 0 0", out_valid, busy);
    end
    tick;
  endtask

  task automatic test_async_reset;
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_msb_first = 1'b0; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_data !== 8'hF0 || out_idx !== 2'd1) begin
      fails++;
      $display("FAIL ar_pre: got d=%h i=%0d, want f0 1", out_data, out_idx);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_idx, out_last, busy} !== 13'd0) begin
      fails++;
      $display("FAIL ar_immediate: got v=%b d=%h i=%0d l=%b b=%b, want all 0",
               out_valid, out_data, out_idx, out_last, busy);
    end
    out_ready = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL ar_post%0d: got v=%b b=%b r=%b, want 0 0 1", i, out_valid, busy, in_ready);
      end
      tick;
    end
  endtask

`ifdef SPLIT_PARITY_EN
  task automatic test_parity;
    logic exp [4];
    exp[0] = 1'b1; exp[1] = 1'b1; exp[2] = 1'b0; exp[3] = 1'b0;
    #1;
    checks++;
    if (out_par !== 1'b0) begin
      fails++;
      $display("FAIL par_idle: got %b, want 0", out_par);
    end
    in_valid = 1'b1; in_data = 32'h00000701; in_msb_first = 1'b0; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_par !== exp[i]) begin
        fails++;
        $display("FAIL par_beat%0d: got %b, want %b", i, out_par, exp[i]);
      end
      tick;
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; out_ready = 1'b0;
    test_reset;
    test_lsb_first;
    test_msb_first;
    test_backpressure;
    test_back_to_back;
    test_async_reset;
`ifdef SPLIT_PARITY_EN
    test_parity;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units, want completion");
    $fatal(1, "timeout");
  end

endmodule
